// File: rtl/psum_in_data_unpackage.sv
// rtl/psum_in_data_unpackage.sv - serialises packed partial-sum stream words back to one bit per handshake
module psum_in_data_unpackage #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [8:0]                      output_channel_size,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_data,
  output logic [8:0]                      out_channel_idx,
  output logic                            out_package_last,
  output logic                            layer_done
);

  localparam int PTR_W = $clog2(C_S_AXIS_TDATA_WIDTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(C_S_AXIS_TDATA_WIDTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                          state_q, state_d;
  logic [C_S_AXIS_TDATA_WIDTH-1:0] word_q, word_d;
  logic [PTR_W-1:0]                bit_ptr_q, bit_ptr_d;
  logic [8:0]                      channel_cnt_q, channel_cnt_d;
  logic                            tlast_q, tlast_d;
  logic [8:0]                      size_q, size_d;
  logic                            armed_q, armed_d;
  logic                            out_valid_q, out_valid_d;
  logic                            out_data_q, out_data_d;
  logic [8:0]                      out_channel_idx_q, out_channel_idx_d;
  logic                            out_package_last_q, out_package_last_d;
  logic                            layer_done_q, layer_done_d;

  logic                            bit_hs;
  logic                            pkg_end;
  logic                            word_end;
  logic                            accept;
  logic [8:0]                      cnt_inc;
  logic [8:0]                      cnt_after;
  logic [8:0]                      size_next;
  logic [PTR_W-1:0]                bit_ptr_inc;

  // Handshake decode and the ready path; ready is combinational so a new word can land in the word-end cycle
  always_comb begin
    bit_hs        = out_valid_q && out_ready;
    cnt_inc       = channel_cnt_q + 9'd1;
    bit_ptr_inc   = bit_ptr_q + PTR_ONE;
    pkg_end       = (cnt_inc == size_q);
    word_end      = pkg_end || (bit_ptr_q == PTR_LAST);
    s_axis_tready = armed_q && ((state_q == IDLE) || (bit_hs && word_end));
    accept        = s_axis_tvalid && s_axis_tready;
    // Size is only taken from the port while idle; back-to-back words keep the latched one
    size_next     = (state_q == IDLE) ? output_channel_size : size_q;
    // Channel count a newly accepted word starts from: a closed package or a layer end restarts at 0
    if (bit_hs && word_end) begin
      cnt_after = (pkg_end || tlast_q) ? 9'd0 : cnt_inc;
    end else begin
      cnt_after = channel_cnt_q;
    end
  end

  // Next-state and registered output computation
  always_comb begin
    state_d            = state_q;
    word_d             = word_q;
    bit_ptr_d          = bit_ptr_q;
    channel_cnt_d      = channel_cnt_q;
    tlast_d            = tlast_q;
    size_d             = size_next;
    armed_d            = 1'b1;
    out_valid_d        = out_valid_q;
    out_data_d         = out_data_q;
    out_channel_idx_d  = out_channel_idx_q;
    out_package_last_d = out_package_last_q;
    layer_done_d       = 1'b0;

    if (bit_hs) begin
      if (word_end) begin
        // Word finished (or package closed early): drop any unused tail bits
        layer_done_d       = tlast_q;
        bit_ptr_d          = '0;
        channel_cnt_d      = cnt_after;
        state_d            = IDLE;
        out_valid_d        = 1'b0;
        out_package_last_d = 1'b0;
      end else begin
        bit_ptr_d          = bit_ptr_inc;
        channel_cnt_d      = cnt_inc;
        out_data_d         = word_q[bit_ptr_inc];
        out_channel_idx_d  = cnt_inc;
        out_package_last_d = ((cnt_inc + 9'd1) == size_q);
      end
    end

    if (accept) begin
      // New word: present bit 0 on the next cycle
      word_d             = s_axis_tdata;
      tlast_d            = s_axis_tlast;
      bit_ptr_d          = '0;
      channel_cnt_d      = cnt_after;
      size_d             = size_next;
      state_d            = SHIFT;
      out_valid_d        = 1'b1;
      out_data_d         = s_axis_tdata[0];
      out_channel_idx_d  = cnt_after;
      out_package_last_d = ((cnt_after + 9'd1) == size_next);
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      word_q             <= '0;
      bit_ptr_q          <= '0;
      channel_cnt_q      <= '0;
      tlast_q            <= 1'b0;
      size_q             <= '0;
      armed_q            <= 1'b0;
      out_valid_q        <= 1'b0;
      out_data_q         <= 1'b0;
      out_channel_idx_q  <= '0;
      out_package_last_q <= 1'b0;
      layer_done_q       <= 1'b0;
    end else begin
      state_q            <= state_d;
      word_q             <= word_d;
      bit_ptr_q          <= bit_ptr_d;
      channel_cnt_q      <= channel_cnt_d;
      tlast_q            <= tlast_d;
      size_q             <= size_d;
      armed_q            <= armed_d;
      out_valid_q        <= out_valid_d;
      out_data_q         <= out_data_d;
      out_channel_idx_q  <= out_channel_idx_d;
      out_package_last_q <= out_package_last_d;
      layer_done_q       <= layer_done_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign out_data         = out_data_q;
  assign out_channel_idx  = out_channel_idx_q;
  assign out_package_last = out_package_last_q;
  assign layer_done       = layer_done_q;

endmodule

// File: doc/psum_in_data_unpackage.md
Name: psum_in_data_unpackage

Overview:
- Receive-side counterpart of the partial-sum output packer.
- Accepts 32-bit AXI4-Stream words whose bits were packed LSB-first, one package per group of output_channel_size channels.
- Re-serialises each word into one bit per handshake, so 1-bit partial sums can be fed back into the PE array (psum reload).
- Sits between the DMA S_AXIS port and the psum input FIFO/accumulator.

Parameters:
C_S_AXIS_TDATA_WIDTH, 32, stream word width; must be a power of two, minimum 2; bit pointer width = clogb2(C_S_AXIS_TDATA_WIDTH-1).

Ports:
clk  input  1  clock.
rst_n  input  1  asynchronous active-low reset.
output_channel_size  input  9  bits per package; 0 means 512; sampled only while state is IDLE.
s_axis_tdata  input  C_S_AXIS_TDATA_WIDTH  packed word, bit 0 first.
s_axis_tvalid  input  1  word valid.
s_axis_tready  output  1  word accepted when tvalid && tready.
s_axis_tlast  input  1  final word of the layer.
out_valid  output  1  serial bit valid.
out_ready  input  1  downstream ready.
out_data  output  1  current bit.
out_channel_idx  output  9  channel index of out_data within its package.
out_package_last  output  1  out_data is the last bit of its package.
layer_done  output  1  one-cycle pulse after the last bit of a tlast word is taken.

Behaviour:
- Reset values: s_axis_tready=0, out_valid=0, out_data=0, out_channel_idx=0, out_package_last=0, layer_done=0.
- All internal state clears on reset: word register, bit_ptr, channel_cnt, tlast flag. Reset mid-word discards the word; nothing is replayed.
- States:
  - IDLE: no word held; tready=1 from the cycle after reset release.
  - SHIFT: word held; out_valid=1.
- Transitions:
  - Word accept moves to SHIFT in the next cycle. Latency: word accepted at cycle N, bit 0 is presented at N+1.
  - Bit handshake fires when out_valid && out_ready. On handshake: bit_ptr+1, channel_cnt+1.
  - Package end: a handshake where channel_cnt+1 == output_channel_size (9-bit compare, so size 0 wraps at 512). channel_cnt returns to 0 and the rest of the word is discarded.
  - Word end: a handshake where bit_ptr == C_S_AXIS_TDATA_WIDTH-1, or a package end.
  - On word end: bit_ptr returns to 0. The next state is SHIFT if a new word is accepted in the same cycle, otherwise IDLE.
- tready = (state==IDLE) || (bit handshake && word end), so 1 bit/cycle is sustained with no bubble between words.
- out_data = word[bit_ptr], registered along with out_channel_idx = channel_cnt.
- out_package_last is high on the bit that causes the package end.
- out_valid is held and data stays stable while out_ready=0 (AXI rules).
- Word bits per package: min(32, remaining channels). A package never spans the unused tail of a word; the next package starts at bit 0 of the next word.
- tlast word:
  - Unpacked normally.
  - On its word-end handshake, layer_done pulses in the next cycle.
  - channel_cnt and bit_ptr are forced to 0, so a layer boundary always starts a fresh package.
- Simultaneous events: a word-end handshake plus a new word accept loads the new word. A layer_done pulse may coincide with the first bit of the next layer.
- tvalid without tready: no state change; tdata is not sampled.

Test Plan:
- size=8, words 0x000000A5 then 0x0000003C, out_ready=1:
  - out_data 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
  - out_package_last on the 8th and 16th bits.
  - tready high in the same cycle as each word-end handshake.
- size=40, words 0xFFFFFFFF, 0x000000FF:
  - 32 ones with idx 0..31, then 8 ones with idx 32..39.
  - package_last only on idx 39.
  - The upper 24 bits of word 2 are never output.
- size=0 (512), 16 words of 0x55555555:
  - 512 alternating bits, idx 0..511.
  - package_last only on the 512th bit; channel_cnt then 0.
- out_ready toggling 1/0 every cycle on size=32, word 0x80000001:
  - out_data held stable while stalled; 32 bits delivered in 63 cycles.
  - tready stays low until bit 31 handshakes.
- size=16, second word carries tlast:
  - layer_done is a single pulse one cycle after the 16th bit of word 2.
  - The next word restarts at idx 0.
- rst_n low after bit 5 of a size=32 word:
  - All outputs go to reset values immediately.
  - After release, the first new word outputs from idx 0, bit 0.
